// File: rtl/block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : block_dispatcher
// Purpose  : Hands every C_ij block index of the result matrix to a free block
//            control unit and reports completion when all blocks are produced.
// Revision : 1.0
// ============================================================================
module block_dispatcher #(
    parameter int NUM_CU = 4,
    parameter int N_BLK  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    output logic [IDX_W-1:0]  o_Row_Index,
    output logic [IDX_W-1:0]  o_Column_Index,
    output logic [NUM_CU-1:0] o_Indexes_Ready,
    input  logic [NUM_CU-1:0] i_Indexes_Received,
    input  logic [NUM_CU-1:0] i_Result_Ready,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error
);
    localparam int CNT_W = $clog2(N_BLK * N_BLK + 1);
    localparam int CU_W  = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;
    localparam logic [CNT_W-1:0] c_TOTAL = CNT_W'(N_BLK * N_BLK);
    localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(N_BLK - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_OFFER  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [IDX_W-1:0]  r_row;
    logic [IDX_W-1:0]  r_col;
    logic [CU_W-1:0]   r_cu;
    logic [NUM_CU-1:0] r_busy;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_completed;
    logic              r_error;

    logic [CU_W-1:0]   w_pick;
    logic              w_any_free;
    logic              w_all_issued;
    logic [NUM_CU-1:0] w_offer_mask;
    logic              w_ack_ok;
    logic              w_ack_bad;
    logic              w_active;
    logic [NUM_CU-1:0] w_res_valid;
    logic              w_res_bad;
    logic [CNT_W-1:0]  w_res_count;

    // Lowest-numbered free CU wins.
    always_comb begin
        w_pick = '0;
        for (int k = NUM_CU - 1; k >= 0; k--) begin
            if (!r_busy[k]) w_pick = CU_W'(k);
        end
    end

    assign w_any_free   = ~&r_busy;
    assign w_all_issued = (r_issued == c_TOTAL);
    assign w_offer_mask = (r_state == S_OFFER) ? (NUM_CU'(1) << r_cu) : '0;
    assign w_ack_ok     = |(i_Indexes_Received & w_offer_mask);
    assign w_ack_bad    = |(i_Indexes_Received & ~w_offer_mask);
    assign w_active     = (r_state != S_IDLE);
    // A result is only legal for a CU already holding a block, so a result
    // arriving with that CU's own ack is flagged.
    assign w_res_valid  = w_active ? (i_Result_Ready & r_busy) : '0;
    assign w_res_bad    = w_active && |(i_Result_Ready & ~r_busy);
    assign w_res_count  = CNT_W'($countones(w_res_valid));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_Start) w_next_state = S_SELECT;
            S_SELECT: begin
                if (w_all_issued)    w_next_state = S_DRAIN;
                else if (w_any_free) w_next_state = S_OFFER;
            end
            S_OFFER:  if (w_ack_ok) w_next_state = S_SELECT;
            S_DRAIN:  if (r_completed == c_TOTAL) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_Indexes_Ready = w_offer_mask;
        o_Row_Index     = r_row;
        o_Column_Index  = r_col;
        o_Busy          = (r_state == S_SELECT) || (r_state == S_OFFER) || (r_state == S_DRAIN);
        o_Done          = (r_state == S_DONE);
        o_Error         = r_error;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_cu        <= '0;
            r_busy      <= '0;
            r_issued    <= '0;
            r_completed <= '0;
            r_error     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_Start) begin
                r_row       <= '0;
                r_col       <= '0;
                r_issued    <= '0;
                r_completed <= '0;
            end else begin
                r_completed <= r_completed + w_res_count;
            end

            if (r_state == S_SELECT && !w_all_issued && w_any_free) r_cu <= w_pick;

            // Row-major walk: column first, then row.
            if (w_ack_ok) begin
                r_issued <= r_issued + 1'b1;
                if (r_col == c_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            r_busy <= (r_busy & ~w_res_valid) | (w_ack_ok ? w_offer_mask : '0);

            if (w_ack_bad || w_res_bad) r_error <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_dispatcher
// Purpose  : Directed protocol checks plus randomized CU behaviour against a
//            transaction-level model of block_dispatcher.
// Revision : 1.0
// ============================================================================
module tb_block_dispatcher;
    localparam int NUM_CU = 2;
    localparam int N_BLK  = 2;
    localparam int IDX_W  = 2;
    localparam int TOTAL  = N_BLK * N_BLK;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [NUM_CU-1:0] rdy;
    logic [NUM_CU-1:0] ack;
    logic [NUM_CU-1:0] res;
    logic              busy;
    logic              done;
    logic              err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    block_dispatcher #(.NUM_CU(NUM_CU), .N_BLK(N_BLK), .IDX_W(IDX_W)) dut (
        .i_Clock            (clk),
        .i_Reset            (rst),
        .i_Start            (start),
        .o_Row_Index        (row),
        .o_Column_Index     (col),
        .o_Indexes_Ready    (rdy),
        .i_Indexes_Received (ack),
        .i_Result_Ready     (res),
        .o_Busy             (busy),
        .o_Done             (done),
        .o_Error            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_offer(input string tag, input int mask, input int r, input int c);
        check({tag, "_rdy"}, 32'(rdy), 32'(mask));
        check({tag, "_row"}, 32'(row), 32'(r));
        check({tag, "_col"}, 32'(col), 32'(c));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ack = '0; res = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Randomized CUs: random ack delay, random result latency; model tracks
    // which CUs hold a block and counts issued/completed blocks.
    task automatic run_random();
        logic [NUM_CU-1:0] hold;
        logic [NUM_CU-1:0] held_rdy;
        logic [NUM_CU-1:0] exp_mask;
        int cd[NUM_CU];
        int issued, completed, wait_cnt, held_cu;
        bit pending, seen_done;
        do_reset();
        hold = '0; issued = 0; completed = 0; pending = 0; seen_done = 0;
        held_rdy = '0; held_cu = 0; wait_cnt = 0;
        for (int m = 0; m < NUM_CU; m++) cd[m] = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (rdy != '0 && !pending) begin
                exp_mask = '0;
                for (int m = NUM_CU - 1; m >= 0; m--)
                    if (!hold[m]) exp_mask = NUM_CU'(1) << m;
                check("rnd_cu", 32'(rdy), 32'(exp_mask));
                check("rnd_blk", 32'(row) * N_BLK + 32'(col), 32'(issued));
                pending  = 1'b1;
                held_rdy = rdy;
                wait_cnt = int'($urandom_range(0, 3));
                for (int m = 0; m < NUM_CU; m++) if (rdy[m]) held_cu = m;
            end else if (pending) begin
                check("rnd_hold", 32'(rdy), 32'(held_rdy));
            end
            completed += $countones(res);
            issued    += (ack != '0) ? 1 : 0;
            hold       = (hold & ~res) | ack;
            if (done) begin
                seen_done = 1'b1;
                check("rnd_done_cmp", 32'(completed), 32'(TOTAL));
                check("rnd_done_iss", 32'(issued), 32'(TOTAL));
                check("rnd_done_busy", 32'(busy), 32'd0);
            end
            ack = '0;
            res = '0;
            for (int m = 0; m < NUM_CU; m++) begin
                if (cd[m] > 0) begin
                    cd[m]--;
                    if (cd[m] == 0) res[m] = 1'b1;
                end
            end
            if (pending) begin
                if (wait_cnt == 0) begin
                    ack = held_rdy;
                    cd[held_cu] = int'($urandom_range(1, 10));
                    pending = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
        check("rnd_timeout", 32'(seen_done), 32'd1);
        ack = '0; res = '0;
        repeat (3) begin
            @(negedge clk);
            check("rnd_done_once", 32'(done), 32'd0);
        end
        check("rnd_err", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = '0; res = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_idx", {28'd0, row, col}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Start latency, held offer, bubble, row-major order.
        pulse_start();
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_rdy0", 32'(rdy), 32'd0);
        @(negedge clk);
        check_offer("first", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_offer("hold", 1, 0, 0);
        end
        ack = 2'b01; @(negedge clk); ack = '0;
        check("bubble1", 32'(rdy), 32'd0);
        @(negedge clk);
        check_offer("second", 2, 0, 1);
        ack = 2'b10; @(negedge clk); ack = '0;
        for (int i = 0; i < 3; i++) begin
            check("allbusy", 32'(rdy), 32'd0);
            @(negedge clk);
        end

        // CU1 result reuse timing.
        res = 2'b10; @(negedge clk); res = '0;
        check("reuse_gap", 32'(rdy), 32'd0);
        @(negedge clk);
        check_offer("reuse", 2, 1, 0);
        ack = 2'b10; @(negedge clk); ack = '0;
        check("bubble2", 32'(rdy), 32'd0);

        // Simultaneous results free both CUs; lowest wins.
        res = 2'b11; @(negedge clk); res = '0;
        check("dual_gap", 32'(rdy), 32'd0);
        @(negedge clk);
        check_offer("last", 1, 1, 1);
        ack = 2'b01; @(negedge clk); ack = '0;
        repeat (2) @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_rdy", 32'(rdy), 32'd0);
        res = 2'b01; @(negedge clk); res = '0;
        check("pre_done", 32'(done), 32'd0);
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("post_done", 32'(done), 32'd0);
        check("start_in_done", 32'(busy), 32'd0);
        check("clean_err", 32'(err), 32'd0);

        // Protocol errors are sticky and do not disturb the walk.
        pulse_start();
        res = 2'b10; @(negedge clk); res = '0;
        check("err_spur", 32'(err), 32'd1);
        check_offer("err_offer", 1, 0, 0);
        ack = 2'b10; @(negedge clk); ack = '0;
        check("err_sticky", 32'(err), 32'd1);
        check_offer("err_held", 1, 0, 0);
        ack = 2'b01; @(negedge clk); ack = '0;
        @(negedge clk);
        check_offer("err_next", 2, 0, 1);
        ack = 2'b10; @(negedge clk); ack = '0;

        // Asynchronous reset mid-run, then a clean restart.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_rdy", 32'(rdy), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_idx", {28'd0, row, col}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        check_offer("restart", 1, 0, 0);
        check("restart_err", 32'(err), 32'd0);

        for (int r = 0; r < 5; r++) run_random();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/block_dispatcher.md
Name: block_dispatcher

Overview:
- Master-side control unit of the matrix coprocessor.
- Walks every C_ij block index of the result matrix and hands each (i, j) pair to a free block-level control unit over the indexes handshake: Indexes_Ready offered, Indexes_Received acknowledged.
- Collects each control unit's Result_Ready, and reports completion once every block of C has been produced.
- Sits between the host start/done interface and the array of NUM_CU block control units.

Parameters:
- NUM_CU, 4, number of block control units served (1..16)
- N_BLK, 4, blocks per matrix side; total blocks = N_BLK*N_BLK
- IDX_W, 2, width of a block row/column index; N_BLK <= 2**IDX_W

Ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset  in  1  reset, asynchronous, active-high
- i_Start  in  1  pulse: begin a full C computation
- o_Row_Index  out  IDX_W  i of the offered C_ij block (shared by all CUs)
- o_Column_Index  out  IDX_W  j of the offered C_ij block
- o_Indexes_Ready  out  NUM_CU  one-hot offer to CU n; zero when no offer
- i_Indexes_Received  in  NUM_CU  CU n acknowledges the offer
- i_Result_Ready  in  NUM_CU  CU n finished its block (1-cycle pulse)
- o_Busy  out  1  high from accepted start until done
- o_Done  out  1  1-cycle pulse when all blocks have completed
- o_Error  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0; indexes 0; busy bitmap 0; counters 0; FSM to S_IDLE. Reset mid-run aborts everything; no o_Done.
- States: S_IDLE, S_SELECT, S_OFFER, S_DRAIN, S_DONE.
- S_IDLE:
  - i_Start=1: load row=0, col=0, issued=0, completed=0; set o_Busy; go to S_SELECT.
  - i_Start while not S_IDLE: ignored.
- S_SELECT:
  - All N_BLK*N_BLK blocks issued: go to S_DRAIN.
  - Else, any CU free in the busy bitmap: pick the lowest-numbered free CU n, assert o_Indexes_Ready[n], go to S_OFFER.
  - Else: stay.
- S_OFFER:
  - o_Indexes_Ready[n] and both indexes held stable until i_Indexes_Received[n] is sampled high.
  - On that edge: Ready cleared, busy[n] set, issued+1, go to S_SELECT.
  - Net effect: one bubble cycle between consecutive offers.
- Index order is row-major: col increments first; at col=N_BLK-1, col wraps to 0 and row increments.
- Acks on bits other than the offered n are ignored and set o_Error.
- Result handling, in any non-idle state:
  - i_Result_Ready[m] with busy[m]=1: clear busy[m], completed+1. Takes effect next cycle, so a CU is reusable in S_SELECT one cycle after its result pulse.
  - i_Result_Ready[m] with busy[m]=0: ignored, set o_Error.
  - Multiple result bits in one cycle: all counted; completed is incremented by popcount.
- Ack and result in the same cycle:
  - Different CUs: both processed.
  - Same CU: the result is invalid because the CU was not yet busy; set o_Error.
- S_DRAIN: wait until completed = N_BLK*N_BLK, then go to S_DONE.
- S_DONE:
  - o_Done=1 for exactly one cycle; o_Busy cleared the same cycle; go to S_IDLE.
  - A start sampled in S_DONE is ignored.
- Counters are sized to hold N_BLK*N_BLK without overflow.
- o_Error is cleared only by reset.
- Latency: start sampled at edge 0 → first offer to CU0 with (0,0) is visible in cycle 2 (one S_SELECT cycle).

Test Plan:
- N_BLK=2, NUM_CU=2, CUs ack next cycle and return results 10 cycles later → offers (0,0)→CU0, (0,1)→CU1, then (1,0),(1,1) after results; o_Done pulses once after 4th result; o_Busy falls the same cycle.
- Ack delayed 5 cycles → o_Indexes_Ready[0] and indexes held constant for all 5 cycles; no second offer.
- All CUs busy, then CU1 result → next offer goes to CU1 exactly 2 cycles later (bitmap update + S_SELECT).
- CU0 and CU1 results in the same cycle → completed +2; both reusable; final o_Done still after block 4.
- Spurious i_Result_Ready[1] while idle CU, and ack on wrong bit → o_Error=1 and stays 1; counters unchanged.
- Reset asserted mid-run after 2 issues → all outputs 0 asynchronously; a new i_Start restarts from (0,0) with o_Error=0.
